// File: rtl/seq_pattern_detector_if.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector_if
//
// Bundles the qualified serial input stream, the soft clear and the detector
// status outputs into one connection.
//
// Parameters:
//   PAT_LEN  pattern length; sets the width of progress
//   CNT_W    width of match_count
//
// Signals:
//   in_valid     producer -> detector  din is sampled only when high
//   din          producer -> detector  serial data bit
//   clear        producer -> detector  synchronous soft clear (state + counter)
//   match        detector -> consumer  high while the full pattern is held
//   progress     detector -> consumer  current matched-prefix length
//   match_count  detector -> consumer  saturating count of full-pattern entries
//
// Modports:
//   master  stimulus / consumer side
//   slave   detector side
// -----------------------------------------------------------------------------
interface seq_pattern_detector_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    localparam int PW = $clog2(PAT_LEN + 1);

    logic             in_valid;
    logic             din;
    logic             clear;
    logic             match;
    logic [PW-1:0]    progress;
    logic [CNT_W-1:0] match_count;

    modport master (
        output in_valid,
        output din,
        output clear,
        input  match,
        input  progress,
        input  match_count
    );

    modport slave (
        input  in_valid,
        input  din,
        input  clear,
        output match,
        output progress,
        output match_count
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector
//
// Moore recogniser for a programmable serial bit pattern. The state is the
// length of the longest pattern prefix that matches the tail of the accepted
// bit stream; the full-length state raises match. Transitions follow KMP
// failure semantics, with the transition table built at elaboration from
// PATTERN.
//
// Parameters:
//   PAT_LEN  pattern length, 2..16
//   PATTERN  pattern value; PATTERN[PAT_LEN-1] is the first bit expected
//   OVERLAP  1 = overlapping detection, 0 = restart from empty after a match
//   CNT_W    width of the match counter
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    seq_pattern_detector_if.slave
//          (in_valid, din, clear in; match, progress, match_count out)
//
// Optional feature:
//   SEQ_PATTERN_DETECTOR_COUNT_EN  when defined, match_count is a saturating
//   count of full-pattern entries; otherwise the counter is removed and
//   match_count is tied to 0.
// -----------------------------------------------------------------------------
module seq_pattern_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    seq_pattern_detector_if.slave  bus
);

    // state        | meaning
    // -------------+---------------------------------------------------------
    // S_IDLE (0)   | no pattern prefix matched
    // 1..PAT_LEN-1 | that many leading pattern bits matched by the last bits
    // S_FULL       | whole pattern matched; match asserted
    // > S_FULL     | unreachable encoding; recovers to S_IDLE on next edge

    localparam int PW    = $clog2(PAT_LEN + 1);
    localparam int TBL_W = (PAT_LEN + 1) * 2 * PW;

    localparam logic [PW-1:0] S_IDLE = '0;
    localparam logic [PW-1:0] S_FULL = PW'(PAT_LEN);

    // Entry (k*2 + b) holds the next state from state k on input bit b: the
    // longest pattern prefix that is a suffix of (first k pattern bits, b).
    function automatic logic [TBL_W-1:0] build_table();
        logic [TBL_W-1:0] tbl;
        int               best;
        int               idx;
        logic             ok;
        logic             sb;
        tbl = '0;
        for (int k = 0; k <= PAT_LEN; k++) begin
            for (int b = 0; b < 2; b++) begin
                best = 0;
                for (int j = 1; j <= PAT_LEN; j++) begin
                    if (j <= k + 1) begin
                        ok = 1'b1;
                        for (int m = 0; m < j; m++) begin
                            idx = k + 1 - j + m;
                            sb  = (idx == k) ? b[0] : PATTERN[PAT_LEN-1-idx];
                            if (sb != PATTERN[PAT_LEN-1-m]) ok = 1'b0;
                        end
                        if (ok) best = j;
                    end
                end
                tbl[(k*2+b)*PW +: PW] = PW'(best);
            end
        end
        return tbl;
    endfunction

    localparam logic [TBL_W-1:0] NXT_TBL = build_table();

    logic [PW-1:0] state_d, state_q;
    int unsigned   row;

    always_comb begin
        state_d = state_q;
        row     = 0;
        if (bus.clear) begin
            state_d = S_IDLE;
        end else if (state_q > S_FULL) begin
            state_d = S_IDLE;
        end else if (bus.in_valid) begin
            // Non-overlapping mode forgets the completed pattern so the new
            // bit is judged as if from an empty history.
            if (OVERLAP == 0 && state_q == S_FULL) begin
                row = {31'd0, bus.din};
            end else begin
                row = (32'(state_q) << 1) + {31'd0, bus.din};
            end
            state_d = NXT_TBL[row*PW +: PW];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.match    = (state_q == S_FULL);
    assign bus.progress = state_q;

`ifdef SEQ_PATTERN_DETECTOR_COUNT_EN
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             enter_full;

    // Counts accepted transitions into FULL, including FULL -> FULL; holding
    // FULL with in_valid low is not a new entry.
    assign enter_full = !bus.clear && bus.in_valid && (state_q <= S_FULL)
                        && (state_d == S_FULL);

    always_comb begin
        cnt_d = cnt_q;
        if (bus.clear) begin
            cnt_d = '0;
        end else if (enter_full && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.match_count = cnt_q;
`else
    assign bus.match_count = '0;
`endif

endmodule
